// File: rtl/conv_line_buffer_streamer.sv
// Row-streaming responder: fills three rotating line buffers from the input BRAM
// and streams one vertical 3-pixel column per beat to the PE.
module conv_line_buffer_streamer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 22,
    parameter int MAX_IMG = 128
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              Input_line_buffer_Reset,
    input  logic              Stream_first_row,
    input  logic              Stream_mid_row,
    input  logic              Stream_last_row,
    input  logic [7:0]        IMAGE_SIZE,
    input  logic [ADDR_W-1:0] ch_base,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DATA_W-1:0] win_top,
    output logic [DATA_W-1:0] win_mid,
    output logic [DATA_W-1:0] win_bot,
    output logic              win_last,
    output logic              Done_1row,
    output logic              Input_line_buffer_IDLE
);
    localparam int IW = $clog2(MAX_IMG);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, STREAM, DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        c_q, c_d;
    logic [7:0]        fcol_q, fcol_d;
    logic [7:0]        frow_q, frow_d;
    logic [7:0]        k_q, k_d;
    logic [1:0]        top_slot_q, top_slot_d;
    logic [1:0]        fslot_q, fslot_d;
    logic              top_zero_q, top_zero_d;
    logic              bot_zero_q, bot_zero_d;
    logic              fsecond_q, fsecond_d;
    logic              bram_en_q, bram_en_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic              win_valid_q, win_valid_d;
    logic              win_last_q, win_last_d;
    logic [DATA_W-1:0] win_top_q, win_top_d;
    logic [DATA_W-1:0] win_mid_q, win_mid_d;
    logic [DATA_W-1:0] win_bot_q, win_bot_d;
    logic              done_q, done_d;
    logic              idle_q, idle_d;

    logic              wr_en_q;
    logic [1:0]        wr_slot_q;
    logic [IW-1:0]     wr_col_q;
    logic [DATA_W-1:0] lb_q [3][MAX_IMG];

    logic [2:0]        sh;
    logic [7:0]        last_col;
    logic [1:0]        mid_slot_d, bot_slot_d;
    logic              handshake;

    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [7:0]        row,
                                                   input logic [7:0]        col,
                                                   input logic [2:0]        shamt);
        logic [ADDR_W-1:0] r;
        logic [ADDR_W-1:0] cc;
        r  = {{(ADDR_W-8){1'b0}}, row};
        cc = {{(ADDR_W-8){1'b0}}, col};
        return base + (r << shamt) + cc;
    endfunction

    always_comb begin
        case (IMAGE_SIZE)
            8'd4:    sh = 3'd2;
            8'd8:    sh = 3'd3;
            8'd16:   sh = 3'd4;
            8'd32:   sh = 3'd5;
            8'd64:   sh = 3'd6;
            default: sh = 3'd7;
        endcase
    end

    assign last_col  = IMAGE_SIZE - 8'd1;
    assign handshake = win_valid_q && win_ready;

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        fcol_d      = fcol_q;
        frow_d      = frow_q;
        k_d         = k_q;
        top_slot_d  = top_slot_q;
        fslot_d     = fslot_q;
        top_zero_d  = top_zero_q;
        bot_zero_d  = bot_zero_q;
        fsecond_d   = fsecond_q;
        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;

        case (state_q)
            IDLE: begin
                if (Stream_first_row) begin
                    c_d         = '0;
                    top_zero_d  = 1'b1;
                    bot_zero_d  = 1'b0;
                    frow_d      = '0;
                    fcol_d      = '0;
                    fslot_d     = slot_inc(top_slot_q);
                    fsecond_d   = 1'b1;
                    bram_en_d   = 1'b1;
                    bram_addr_d = row_addr(ch_base, 8'd0, 8'd0, sh);
                    state_d     = FETCH;
                end else if (Stream_mid_row) begin
                    // Old TOP slot is freed by the rotation and becomes the new BOT.
                    c_d         = c_q + 8'd1;
                    top_slot_d  = slot_inc(top_slot_q);
                    top_zero_d  = 1'b0;
                    bot_zero_d  = 1'b0;
                    frow_d      = c_q + 8'd2;
                    fcol_d      = '0;
                    fslot_d     = top_slot_q;
                    fsecond_d   = 1'b0;
                    bram_en_d   = 1'b1;
                    bram_addr_d = row_addr(ch_base, c_q + 8'd2, 8'd0, sh);
                    state_d     = FETCH;
                end else if (Stream_last_row) begin
                    c_d        = c_q + 8'd1;
                    top_slot_d = slot_inc(top_slot_q);
                    top_zero_d = 1'b0;
                    bot_zero_d = 1'b1;
                    k_d        = '0;
                    state_d    = STREAM;
                end
            end
            FETCH: begin
                if (fcol_q == last_col) begin
                    if (fsecond_q) begin
                        frow_d      = frow_q + 8'd1;
                        fcol_d      = '0;
                        fslot_d     = slot_inc(fslot_q);
                        fsecond_d   = 1'b0;
                        bram_en_d   = 1'b1;
                        bram_addr_d = row_addr(ch_base, frow_q + 8'd1, 8'd0, sh);
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else begin
                    fcol_d      = fcol_q + 8'd1;
                    bram_en_d   = 1'b1;
                    bram_addr_d = row_addr(ch_base, frow_q, fcol_q + 8'd1, sh);
                end
            end
            WAIT_RD: begin
                k_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (handshake) begin
                    if (k_q == last_col) state_d = DONE;
                    else                 k_d     = k_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!Input_line_buffer_Reset) begin
            state_d     = IDLE;
            c_d         = '0;
            k_d         = '0;
            top_slot_d  = '0;
            top_zero_d  = 1'b0;
            bot_zero_d  = 1'b0;
            fsecond_d   = 1'b0;
            bram_en_d   = 1'b0;
            bram_addr_d = '0;
        end

        // Window registers are reloaded from the buffers every cycle; during a stall
        // k and the buffers are unchanged, so the presented beat stays stable.
        mid_slot_d  = slot_inc(top_slot_d);
        bot_slot_d  = slot_inc(mid_slot_d);
        win_valid_d = (state_d == STREAM);
        win_last_d  = win_valid_d && (k_d == last_col);
        win_top_d   = (win_valid_d && !top_zero_d) ? lb_q[top_slot_d][k_d[IW-1:0]] : '0;
        win_mid_d   = win_valid_d ? lb_q[mid_slot_d][k_d[IW-1:0]] : '0;
        win_bot_d   = (win_valid_d && !bot_zero_d) ? lb_q[bot_slot_d][k_d[IW-1:0]] : '0;
        done_d      = (state_d == DONE);
        idle_d      = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            c_q         <= '0;
            fcol_q      <= '0;
            frow_q      <= '0;
            k_q         <= '0;
            top_slot_q  <= '0;
            fslot_q     <= '0;
            top_zero_q  <= 1'b0;
            bot_zero_q  <= 1'b0;
            fsecond_q   <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_top_q   <= '0;
            win_mid_q   <= '0;
            win_bot_q   <= '0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_slot_q   <= '0;
            wr_col_q    <= '0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            fcol_q      <= fcol_d;
            frow_q      <= frow_d;
            k_q         <= k_d;
            top_slot_q  <= top_slot_d;
            fslot_q     <= fslot_d;
            top_zero_q  <= top_zero_d;
            bot_zero_q  <= bot_zero_d;
            fsecond_q   <= fsecond_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_top_q   <= win_top_d;
            win_mid_q   <= win_mid_d;
            win_bot_q   <= win_bot_d;
            done_q      <= done_d;
            idle_q      <= idle_d;
            wr_en_q     <= bram_en_q;
            wr_slot_q   <= fslot_q;
            wr_col_q    <= fcol_q[IW-1:0];
        end
    end

    // Line buffer storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_q) lb_q[wr_slot_q][wr_col_q] <= bram_dout;
    end

    assign bram_en                = bram_en_q;
    assign bram_addr              = bram_addr_q;
    assign win_valid              = win_valid_q;
    assign win_last               = win_last_q;
    assign win_top                = win_top_q;
    assign win_mid                = win_mid_q;
    assign win_bot                = win_bot_q;
    assign Done_1row              = done_q;
    assign Input_line_buffer_IDLE = idle_q;

endmodule

// File: tb/tb_conv_line_buffer_streamer.sv
// Directed self-checking bench for conv_line_buffer_streamer with a BRAM model holding BRAM[a] = a.
module tb_conv_line_buffer_streamer;
    localparam int DW = 16;
    localparam int AW = 22;

    typedef struct packed {
        logic [DW-1:0] t;
        logic [DW-1:0] m;
        logic [DW-1:0] b;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          Input_line_buffer_Reset;
    logic          Stream_first_row, Stream_mid_row, Stream_last_row;
    logic [7:0]    IMAGE_SIZE;
    logic [AW-1:0] ch_base;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic          win_valid, win_ready;
    logic [DW-1:0] win_top, win_mid, win_bot;
    logic          win_last, Done_1row, Input_line_buffer_IDLE;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cT = 0;
    int first_valid_cyc = -1;
    logic [AW-1:0] rd_q[$];
    beat_t         beats[$];

    conv_line_buffer_streamer #(.DATA_W(DW), .ADDR_W(AW), .MAX_IMG(128)) dut (
        .clk                    (clk),
        .aresetn                (aresetn),
        .Input_line_buffer_Reset(Input_line_buffer_Reset),
        .Stream_first_row       (Stream_first_row),
        .Stream_mid_row         (Stream_mid_row),
        .Stream_last_row        (Stream_last_row),
        .IMAGE_SIZE             (IMAGE_SIZE),
        .ch_base                (ch_base),
        .bram_en                (bram_en),
        .bram_addr              (bram_addr),
        .bram_dout              (bram_dout),
        .win_valid              (win_valid),
        .win_ready              (win_ready),
        .win_top                (win_top),
        .win_mid                (win_mid),
        .win_bot                (win_bot),
        .win_last               (win_last),
        .Done_1row              (Done_1row),
        .Input_line_buffer_IDLE (Input_line_buffer_IDLE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_en) bram_dout <= bram_addr[DW-1:0];
    end

    always @(negedge clk) begin
        if (bram_en) rd_q.push_back(bram_addr);
        if (win_valid && win_ready) beats.push_back({win_top, win_mid, win_bot, win_last});
        if (win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        rd_q.delete();
        beats.delete();
        first_valid_cyc = -1;
    endtask

    task automatic send_cmd(input logic f, input logic m, input logic l);
        @(posedge clk); #1;
        Stream_first_row = f; Stream_mid_row = m; Stream_last_row = l;
        @(posedge clk); #1;
        Stream_first_row = 1'b0; Stream_mid_row = 1'b0; Stream_last_row = 1'b0;
        cT = cyc;
    endtask

    task automatic wait_done(input int maxc, output bit ok, output int dc);
        ok = 1'b0;
        dc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (Done_1row === 1'b1) begin
                ok = 1'b1;
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        checks++; if (bram_en !== 1'b0) begin failures++; $display("FAIL rst_bram_en got=%b exp=0", bram_en); end
        checks++; if (bram_addr !== '0) begin failures++; $display("FAIL rst_bram_addr got=%0d exp=0", bram_addr); end
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL rst_win_valid got=%b exp=0", win_valid); end
        checks++; if (win_last !== 1'b0) begin failures++; $display("FAIL rst_win_last got=%b exp=0", win_last); end
        checks++; if ({win_top, win_mid, win_bot} !== '0) begin failures++; $display("FAIL rst_win_data got=%h exp=0", {win_top, win_mid, win_bot}); end
        checks++; if (Done_1row !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", Done_1row); end
        checks++; if (Input_line_buffer_IDLE !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", Input_line_buffer_IDLE); end
    endtask

    task automatic test_first_row();
        bit ok;
        int dc;
        beat_t exp;
        IMAGE_SIZE = 8'd4; ch_base = '0; win_ready = 1'b1;
        clear_mon();
        send_cmd(1'b1, 1'b0, 1'b0);
        checks++; if (Input_line_buffer_IDLE !== 1'b0) begin failures++; $display("FAIL first_idle_drop got=%b exp=0", Input_line_buffer_IDLE); end
        checks++; if (bram_en !== 1'b1 || bram_addr !== '0) begin failures++; $display("FAIL first_bram_en got=%b/%0d exp=1/0", bram_en, bram_addr); end
        wait_done(100, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL first_done_timeout got=none exp=pulse"); end
        checks++; if (rd_q.size() != 8) begin failures++; $display("FAIL first_read_count got=%0d exp=8", rd_q.size()); end
        for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] !== AW'(i)) begin failures++; $display("FAIL first_read_addr[%0d] got=%0d exp=%0d", i, rd_q[i], i); end
        end
        checks++; if (beats.size() != 4) begin failures++; $display("FAIL first_beat_count got=%0d exp=4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            exp = {16'd0, 16'(i), 16'(4 + i), (i == 3)};
            checks++; if (beats[i] !== exp) begin failures++; $display("FAIL first_beat[%0d] got=%h exp=%h", i, beats[i], exp); end
        end
        checks++; if (first_valid_cyc != cT + 9) begin failures++; $display("FAIL first_valid_time got=%0d exp=%0d", first_valid_cyc, cT + 9); end
        checks++; if (dc != cT + 13) begin failures++; $display("FAIL first_done_time got=%0d exp=%0d", dc, cT + 13); end
        @(negedge clk);
        checks++; if (Done_1row !== 1'b0 || Input_line_buffer_IDLE !== 1'b1) begin failures++; $display("FAIL first_back_idle got=%b/%b exp=0/1", Done_1row, Input_line_buffer_IDLE); end
    endtask

    task automatic test_mid_last();
        int nrd [3];
        int rbase [3];
        int t0 [3];
        int m0 [3];
        int b0 [3];
        int fv [3];
        int dn [3];
        bit ok;
        int dc;
        beat_t exp;
        nrd = '{4, 4, 0}; rbase = '{8, 12, 0};
        t0 = '{0, 4, 8}; m0 = '{4, 8, 12}; b0 = '{8, 12, 0};
        fv = '{5, 5, 0}; dn = '{9, 9, 4};
        for (int r = 0; r < 3; r++) begin
            clear_mon();
            if (r < 2) send_cmd(1'b0, 1'b1, 1'b0);
            else       send_cmd(1'b0, 1'b0, 1'b1);
            wait_done(100, ok, dc);
            checks++; if (!ok) begin failures++; $display("FAIL row%0d_done_timeout got=none exp=pulse", r); end
            checks++; if (rd_q.size() != nrd[r]) begin failures++; $display("FAIL row%0d_read_count got=%0d exp=%0d", r, rd_q.size(), nrd[r]); end
            for (int i = 0; i < nrd[r] && i < rd_q.size(); i++) begin
                checks++; if (rd_q[i] !== AW'(rbase[r] + i)) begin failures++; $display("FAIL row%0d_read_addr[%0d] got=%0d exp=%0d", r, i, rd_q[i], rbase[r] + i); end
            end
            checks++; if (beats.size() != 4) begin failures++; $display("FAIL row%0d_beat_count got=%0d exp=4", r, beats.size()); end
            if (beats.size() == 4) begin
                exp = {16'(t0[r]), 16'(m0[r]), 16'(b0[r]), 1'b0};
                checks++; if (beats[0] !== exp) begin failures++; $display("FAIL row%0d_beat0 got=%h exp=%h", r, beats[0], exp); end
                exp = {16'(t0[r] + 3), 16'(m0[r] + 3), (r == 2) ? 16'd0 : 16'(b0[r] + 3), 1'b1};
                checks++; if (beats[3] !== exp) begin failures++; $display("FAIL row%0d_beat3 got=%h exp=%h", r, beats[3], exp); end
            end
            checks++; if (first_valid_cyc != cT + fv[r]) begin failures++; $display("FAIL row%0d_valid_time got=%0d exp=%0d", r, first_valid_cyc, cT + fv[r]); end
            checks++; if (dc != cT + dn[r]) begin failures++; $display("FAIL row%0d_done_time got=%0d exp=%0d", r, dc, cT + dn[r]); end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        bit have_prev;
        logic prev_ready;
        int stalls;
        beat_t snap, cur, exp;
        IMAGE_SIZE = 8'd8; ch_base = '0; win_ready = 1'b1;
        clear_mon();
        send_cmd(1'b1, 1'b0, 1'b0);
        seen = 1'b0; have_prev = 1'b0; prev_ready = 1'b1; stalls = 0; snap = '0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            win_ready = ~win_ready;
            @(negedge clk);
            if (Done_1row === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (win_valid === 1'b1) begin
                cur = {win_top, win_mid, win_bot, win_last};
                if (have_prev && !prev_ready) begin
                    stalls++;
                    checks++; if (cur !== snap) begin failures++; $display("FAIL stall_hold got=%h exp=%h", cur, snap); end
                end
                snap = cur;
                prev_ready = win_ready;
                have_prev = 1'b1;
            end
        end
        win_ready = 1'b1;
        checks++; if (!seen) begin failures++; $display("FAIL bp_done_timeout got=none exp=pulse"); end
        checks++; if (stalls == 0) begin failures++; $display("FAIL bp_stall_seen got=0 exp=>0"); end
        checks++; if (rd_q.size() != 16) begin failures++; $display("FAIL bp_read_count got=%0d exp=16", rd_q.size()); end
        checks++; if (beats.size() != 8) begin failures++; $display("FAIL bp_beat_count got=%0d exp=8", beats.size()); end
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            exp = {16'd0, 16'(i), 16'(8 + i), (i == 7)};
            checks++; if (beats[i] !== exp) begin failures++; $display("FAIL bp_beat[%0d] got=%h exp=%h", i, beats[i], exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_priority_busy();
        bit ok;
        int dc;
        beat_t exp;
        IMAGE_SIZE = 8'd4; ch_base = '0; win_ready = 1'b1;
        clear_mon();
        send_cmd(1'b1, 1'b0, 1'b1);
        @(posedge clk); #1 Stream_mid_row = 1'b1;
        @(posedge clk); #1 Stream_mid_row = 1'b0;
        repeat (7) @(posedge clk);
        #1 Stream_last_row = 1'b1;
        @(posedge clk); #1 Stream_last_row = 1'b0;
        wait_done(100, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL prio_done_timeout got=none exp=pulse"); end
        checks++; if (rd_q.size() != 8) begin failures++; $display("FAIL prio_read_count got=%0d exp=8", rd_q.size()); end
        checks++; if (beats.size() != 4) begin failures++; $display("FAIL prio_beat_count got=%0d exp=4", beats.size()); end
        if (beats.size() > 0) begin
            exp = {16'd0, 16'd0, 16'd4, 1'b0};
            checks++; if (beats[0] !== exp) begin failures++; $display("FAIL prio_beat0 got=%h exp=%h", beats[0], exp); end
        end
        repeat (5) @(negedge clk);
        checks++; if (rd_q.size() != 8 || beats.size() != 4) begin failures++; $display("FAIL busy_cmd_ignored got=%0d/%0d exp=8/4", rd_q.size(), beats.size()); end
        checks++; if (Input_line_buffer_IDLE !== 1'b1) begin failures++; $display("FAIL busy_idle got=%b exp=1", Input_line_buffer_IDLE); end
    endtask

    task automatic test_soft_reset();
        IMAGE_SIZE = 8'd4; ch_base = '0; win_ready = 1'b1;
        clear_mon();
        send_cmd(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1 Input_line_buffer_Reset = 1'b0;
        @(posedge clk); #1 Input_line_buffer_Reset = 1'b1;
        checks++; if (Input_line_buffer_IDLE !== 1'b1 || bram_en !== 1'b0) begin failures++; $display("FAIL soft_rst_idle got=%b/%b exp=1/0", Input_line_buffer_IDLE, bram_en); end
        repeat (4) @(negedge clk);
        checks++; if (rd_q.size() != 2) begin failures++; $display("FAIL soft_rst_reads got=%0d exp=2", rd_q.size()); end
        checks++; if (win_valid !== 1'b0 || Done_1row !== 1'b0) begin failures++; $display("FAIL soft_rst_quiet got=%b/%b exp=0/0", win_valid, Done_1row); end
    endtask

    task automatic test_async_reset();
        IMAGE_SIZE = 8'd4; ch_base = '0; win_ready = 1'b1;
        clear_mon();
        send_cmd(1'b1, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        checks++; if (win_valid !== 1'b1 || {win_top, win_mid, win_bot} !== {16'd0, 16'd2, 16'd6}) begin
            failures++; $display("FAIL arst_pre_beat2 got=%b/%h exp=1/000000020006", win_valid, {win_top, win_mid, win_bot});
        end
        #2 aresetn = 1'b0;
        #1;
        checks++; if (win_valid !== 1'b0 || win_last !== 1'b0 || bram_en !== 1'b0 || Done_1row !== 1'b0) begin
            failures++; $display("FAIL arst_ctrl got=%b%b%b%b exp=0000", win_valid, win_last, bram_en, Done_1row);
        end
        checks++; if ({win_top, win_mid, win_bot} !== '0) begin failures++; $display("FAIL arst_data got=%h exp=0", {win_top, win_mid, win_bot}); end
        repeat (2) @(posedge clk);
        @(negedge clk) aresetn = 1'b1;
        @(negedge clk);
        checks++; if (Input_line_buffer_IDLE !== 1'b1) begin failures++; $display("FAIL arst_idle got=%b exp=1", Input_line_buffer_IDLE); end
        test_first_row();
    endtask

    task automatic test_large();
        bit ok;
        int dc;
        beat_t exp;
        IMAGE_SIZE = 8'd128; ch_base = AW'(16384); win_ready = 1'b1;
        clear_mon();
        send_cmd(1'b1, 1'b0, 1'b0);
        wait_done(600, ok, dc);
        checks++; if (!ok) begin failures++; $display("FAIL large_done_timeout got=none exp=pulse"); end
        checks++; if (rd_q.size() != 256) begin failures++; $display("FAIL large_read_count got=%0d exp=256", rd_q.size()); end
        if (rd_q.size() == 256) begin
            checks++; if (rd_q[0] !== AW'(16384)) begin failures++; $display("FAIL large_first_addr got=%0d exp=16384", rd_q[0]); end
            checks++; if (rd_q[128] !== AW'(16512)) begin failures++; $display("FAIL large_row1_addr got=%0d exp=16512", rd_q[128]); end
            checks++; if (rd_q[255] !== AW'(16639)) begin failures++; $display("FAIL large_last_addr got=%0d exp=16639", rd_q[255]); end
        end
        checks++; if (beats.size() != 128) begin failures++; $display("FAIL large_beat_count got=%0d exp=128", beats.size()); end
        if (beats.size() == 128) begin
            exp = {16'd0, 16'd16384, 16'd16512, 1'b0};
            checks++; if (beats[0] !== exp) begin failures++; $display("FAIL large_beat0 got=%h exp=%h", beats[0], exp); end
            exp = {16'd0, 16'd16510, 16'd16638, 1'b0};
            checks++; if (beats[126] !== exp) begin failures++; $display("FAIL large_beat126 got=%h exp=%h", beats[126], exp); end
            exp = {16'd0, 16'd16511, 16'd16639, 1'b1};
            checks++; if (beats[127] !== exp) begin failures++; $display("FAIL large_beat127 got=%h exp=%h", beats[127], exp); end
        end
        checks++; if (dc != cT + 385) begin failures++; $display("FAIL large_done_time got=%0d exp=%0d", dc, cT + 385); end
    endtask

    initial begin
        aresetn = 1'b0;
        Input_line_buffer_Reset = 1'b1;
        Stream_first_row = 1'b0; Stream_mid_row = 1'b0; Stream_last_row = 1'b0;
        IMAGE_SIZE = 8'd4; ch_base = '0; win_ready = 1'b1;
        test_reset();
        test_first_row();
        test_mid_last();
        test_backpressure();
        test_priority_busy();
        test_soft_reset();
        test_async_reset();
        test_large();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
